// File: rtl/para_pkg.sv
// para_pkg: shared constants, state and section types
// for the parameter streamer.
package para_pkg;

  localparam int FM_DEPTH    = 64;
  localparam int CHANNEL_NUM = 128;
  localparam int PARA_WIDTH  = 16;
  localparam int PARA_NUM    = 6;

  function automatic int total_of(
    input int fm,
    input int ch
  );
    return fm + 5 * ch;
  endfunction

  localparam int TOTAL = total_of(FM_DEPTH, CHANNEL_NUM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    SEC_RSIGN = 3'd0,
    SEC_BN_A  = 3'd1,
    SEC_BN_B  = 3'd2,
    SEC_BETA  = 3'd3,
    SEC_GAMMA = 3'd4,
    SEC_ZETA  = 3'd5
  } sec_t;

  // Section of word idx; saturates at the last section.
  function automatic sec_t sec_of(
    input int idx,
    input int fm,
    input int ch,
    input int nsec
  );
    logic [2:0] s;
    s = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (k < nsec && idx >= fm + (k - 1) * ch)
        s = 3'(k);
    end
    return sec_t'(s);
  endfunction

endpackage

// File: rtl/para_skid_fifo.sv
// para_skid_fifo: 2-entry FIFO absorbing memory read
// latency between the reader and the stream output.
module para_skid_fifo #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic signed [W-1:0] push_data,
  input  logic                pop,
  output logic signed [W-1:0] head,
  output logic [1:0]          count
);

  logic signed [W-1:0] ram [2];
  logic                wptr;
  logic                rptr;

  assign head = ram[rptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram[0] <= '0;
      ram[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        ram[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/para_streamer.sv
// para_streamer: streams one full parameter set from
// memory into a valid/ready output, tagged by section.
module para_streamer #(
  parameter int FM_DEPTH    = para_pkg::FM_DEPTH,
  parameter int CHANNEL_NUM = para_pkg::CHANNEL_NUM,
  parameter int PARA_WIDTH  = para_pkg::PARA_WIDTH,
  parameter int PARA_NUM    = para_pkg::PARA_NUM,
  parameter int ADDR_W      = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic signed [PARA_WIDTH-1:0] mem_rd_data,
  output logic signed [PARA_WIDTH-1:0] para_out,
  output logic                         data_out_valid,
  input  logic                         para_ready,
  output logic                         mode_out,
  output logic [2:0]                   sec_id,
  output logic                         busy,
  output logic                         done
);

  import para_pkg::*;

  localparam int N_WORDS = total_of(FM_DEPTH, CHANNEL_NUM);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);

  state_t            state;
  logic              rd_v;
  logic [1:0]        cnt;
  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] out_idx;

  // Slots claimed after this edge: buffered + in flight - leaving.
  assign pop   = data_out_valid && para_ready;
  assign occ   = 3'(cnt) + 3'(rd_v) - 3'(pop);
  assign issue = (state == ST_LOAD) && (occ < 3'd2);

  assign mem_rd_en      = issue;
  assign data_out_valid = (cnt != 2'd0);
  assign busy = (state == ST_LOAD) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);
  assign sec_id = sec_of(int'(out_idx), FM_DEPTH,
                         CHANNEL_NUM, PARA_NUM);

  para_skid_fifo #(
    .W (PARA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_v),
    .push_data (mem_rd_data),
    .pop       (pop),
    .head      (para_out),
    .count     (cnt)
  );

  // Control FSM, read address and output word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      rd_v     <= 1'b0;
      out_idx  <= '0;
      mode_out <= 1'b0;
    end else begin
      rd_v <= issue;
      if (issue)
        mem_addr <= mem_addr + 1'b1;
      if (pop)
        out_idx <= out_idx + 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            mem_addr <= '0;
            out_idx  <= '0;
            mode_out <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (issue && mem_addr == LAST)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && out_idx == LAST) begin
            state    <= ST_DONE;
            mode_out <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_para_streamer.sv
// tb_para_streamer: directed checks of para_streamer
// ordering, sections, backpressure, restart and abort.
module tb_para_streamer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               para_ready;
  logic               mem_rd_en;
  logic [9:0]         mem_addr;
  logic signed [15:0] mem_rd_data;
  logic signed [15:0] para_out;
  logic               data_out_valid;
  logic               mode_out;
  logic [2:0]         sec_id;
  logic               busy;
  logic               done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  para_streamer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rd_data    (mem_rd_data),
    .para_out       (para_out),
    .data_out_valid (data_out_valid),
    .para_ready     (para_ready),
    .mode_out       (mode_out),
    .sec_id         (sec_id),
    .busy           (busy),
    .done           (done)
  );

  // Memory holds mem[k] = k; one-cycle read latency.
  always @(posedge clk)
    if (mem_rd_en)
      mem_rd_data <= {6'd0, mem_addr};

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_sec(input int i);
    if (i < 64)
      return 0;
    if (i >= 64 + 4 * 128)
      return 5;
    return 1 + (i - 64) / 128;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, data_out_valid, 0);
    chk({tag, "_data"}, para_out, 0);
    chk({tag, "_sec"}, sec_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mode"}, mode_out, 0);
    chk({tag, "_rden"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
  endtask

  // rmode: 0 always ready, 1 random, 2 stalled 20+ cycles at word 0
  task automatic stream(
    input int rmode,
    input int repulse_at,
    input int abort_at
  );
    int          nxt;
    int          cyc;
    int          outst;
    int          dones;
    int          r;
    logic        stalled;
    logic [15:0] prev;
    logic [2:0]  prevsec;
    nxt = 0; cyc = 0; outst = 0; dones = 0;
    stalled = 1'b0; prev = '0; prevsec = '0;
    start = 1'b1;
    para_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (nxt < 704 && cyc < 6000) begin
      case (rmode)
        0:       r = 1;
        1:       r = int'($urandom_range(0, 1));
        default: r = (cyc > 22) ? 1 : 0;
      endcase
      if (abort_at >= 0 && nxt == abort_at) begin
        rst = 1'b1;
        start = 1'b1;
        para_ready = 1'b0;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk_reset("abort");
        tick();
        chk("abort_quiet", data_out_valid, 0);
        return;
      end
      para_ready = r[0];
      start = (nxt == repulse_at);
      #1;
      if (cyc == 1) begin
        chk("acc_busy", busy, 1);
        chk("acc_mode", mode_out, 0);
        chk("acc_rden", mem_rd_en, 1);
        chk("acc_addr", mem_addr, 0);
      end
      if (cyc == 2)
        chk("lat_v2", data_out_valid, 0);
      if (cyc == 3)
        chk("lat_v3", data_out_valid, 1);
      if (stalled) begin
        chk("stall_v", data_out_valid, 1);
        chk("stall_d", para_out, prev);
        chk("stall_sec", sec_id, prevsec);
      end
      if (rmode == 2 && cyc >= 5 && cyc <= 22) begin
        chk("hold_v", data_out_valid, 1);
        chk("hold_d", para_out, 0);
        chk("hold_rden", mem_rd_en, 0);
      end
      if (done)
        dones++;
      if (mem_rd_en)
        outst++;
      if (data_out_valid && r[0]) begin
        chk("word", para_out, nxt);
        chk("sec", sec_id, exp_sec(nxt));
        nxt++;
        outst--;
      end
      chk("occ", outst <= 2, 1);
      stalled = data_out_valid && !r[0];
      prev = para_out;
      prevsec = sec_id;
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("complete", nxt, 704);
    chk("early_done", dones, 0);
    chk("done_pulse", done, 1);
    chk("done_mode", mode_out, 1);
    chk("done_busy", busy, 0);
    chk("done_rden", mem_rd_en, 0);
    tick();
    chk("done_clr", done, 0);
    chk("mode_hold", mode_out, 1);
    chk("post_valid", data_out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    para_ready = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    tick();
    chk_reset("reset");
    rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", data_out_valid, 0);
    stream(0, -1, -1);
    tick();
    stream(1, -1, -1);
    tick();
    stream(0, 100, -1);
    tick();
    stream(0, -1, 300);
    stream(0, -1, -1);
    tick();
    stream(2, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/para_streamer.md
PARA_STREAMER -- requirements
Module: para_streamer

Interface
REQ-001 SHALL have parameters: FM_DEPTH 64 (rsign entry count); CHANNEL_NUM 128 (per-channel entry count); PARA_WIDTH 16 (word width); PARA_NUM 6 (section count); ADDR_W 10 (width of the parameter-memory address).
REQ-002 SHALL have one clock and a synchronous active-high reset. Ports, in order:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to stream one full parameter set.
- mem_rd_en  out  1  parameter-memory read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rd_data  in  PARA_WIDTH signed  read data, valid exactly 1 cycle after mem_rd_en.
- para_out  out  PARA_WIDTH signed  streamed word.
- data_out_valid  out  1  para_out is valid.
- para_ready  in  1  downstream accepts; a word transfers when data_out_valid && para_ready.
- mode_out  out  1  0 while loading, 1 once the set is complete.
- sec_id  out  3  section of the current para_out: 0 rsign, 1 bn_a, 2 bn_b, 3 beta, 4 gamma, 5 zeta.
- busy  out  1  a stream is in progress.
- done  out  1  one-cycle pulse after the last word transfers.

Function
REQ-003 SHALL emit TOTAL = FM_DEPTH + 5*CHANNEL_NUM words (704 by default) per start.
REQ-004 SHALL emit words in this order: FM_DEPTH rsign words, then CHANNEL_NUM words each of bn_a, bn_b, beta, gamma, zeta; memory address k maps to stream word k.
REQ-005 SHALL implement states IDLE, LOAD, DRAIN, DONE:
- IDLE->LOAD on start.
- LOAD->DRAIN in the cycle the read of address TOTAL-1 issues.
- DRAIN->DONE when the last word transfers.
- DONE->IDLE unconditionally after one cycle.
REQ-006 SHALL ignore start outside IDLE.
REQ-007 SHALL issue a read in LOAD only when (fifo_count + inflight - pop) < 2, where pop = data_out_valid && para_ready; mem_addr increments by 1 per issued read.
REQ-008 SHALL buffer read data in a 2-entry FIFO; para_out/data_out_valid SHALL come from the FIFO head; no word may be dropped or duplicated under any para_ready pattern.
REQ-009 SHALL sustain 1 word/cycle while para_ready is held high.
REQ-010 SHALL assert the first data_out_valid 3 cycles after start is sampled (read issued at +1, FIFO written at +2, visible at +3).
REQ-011 SHALL hold para_out and sec_id stable while data_out_valid && !para_ready.
REQ-012 SHALL derive sec_id from the word index: it becomes 1 at index FM_DEPTH, then increments every CHANNEL_NUM words, saturating at 5.
REQ-013 SHALL deassert mode_out on start acceptance and assert it in the DONE cycle; it SHALL stay 1 until the next accepted start.
REQ-014 SHALL assert busy in LOAD and DRAIN only.
REQ-015 SHALL hold mem_rd_en low outside LOAD.

Reset
REQ-016 SHALL, on rst, drive state IDLE, FIFO empty, inflight 0, mem_addr 0, mem_rd_en 0, para_out 0, data_out_valid 0, sec_id 0, busy 0, done 0, mode_out 0.
REQ-017 SHALL abort an in-progress stream on rst with no further valid words; rst dominates a simultaneous start.

Structure
REQ-018 SHALL take FM_DEPTH, CHANNEL_NUM, PARA_WIDTH, PARA_NUM, the TOTAL constant, the state enum and the sec_id enum from a shared package, para_pkg.
REQ-019 SHALL place the 2-entry FIFO in one sub-module, para_skid_fifo, with push/pop/count ports.

Verification
REQ-020 SHALL cover: mem[k]=k, para_ready=1, start pulse -> 704 words 0..703 on consecutive cycles from start+3; done at word 703 transfer+1; mode_out=1.
REQ-021 SHALL cover sec_id boundaries: word 63 sec_id=0, word 64 sec_id=1, word 191 sec_id=1, word 192 sec_id=2, word 703 sec_id=5.
REQ-022 SHALL cover backpressure: para_ready random 50%/cycle -> identical 704-word sequence, stable para_out during stalls, never more than 2 reads outstanding+buffered.
REQ-023 SHALL cover: start re-pulsed at word 100 -> ignored, stream uninterrupted, single done.
REQ-024 SHALL cover: rst at word 300, then a new start -> outputs per REQ-016 within 1 cycle, then a full 704-word stream from word 0.
REQ-025 SHALL cover: para_ready=0 held for 20 cycles at word 0 -> data_out_valid high with para_out=mem[0] throughout, mem_rd_en low after the FIFO fills.
